// File: rtl/integer_wb_buffer.sv
// Integer execute result buffer feeding the ROB integer write-back port.
// Optional zero-latency bypass when the buffer is empty: define INTEGER_WB_BYPASS_EN.
module integer_wb_buffer #(
   parameter int DEPTH         = 4,
   parameter int MISPRED_CNT_W = 16,
   parameter int ROB_ID_W      = 6
) (
   input  logic                     clk,
   input  logic                     rst_aL,
   input  logic                     exe_valid,
   output logic                     exe_ready,
   input  logic [ROB_ID_W-1:0]      exe_rob_id,
   input  logic                     exe_dst_valid,
   input  logic [31:0]              exe_dst,
   input  logic                     exe_npc_wb_valid,
   input  logic                     exe_npc_mispred,
   input  logic [31:0]              exe_npc,
   input  logic                     flush,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [ROB_ID_W-1:0]      wb_rob_id,
   output logic                     wb_dst_valid,
   output logic [31:0]              wb_dst,
   output logic                     wb_npc_valid,
   output logic [31:0]              wb_npc,
   output logic                     wb_mispred,
   output logic [MISPRED_CNT_W-1:0] mispred_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [ROB_ID_W-1:0] mem_rob_id    [DEPTH];
   logic                mem_dst_valid [DEPTH];
   logic [31:0]         mem_dst       [DEPTH];
   logic                mem_npc_valid [DEPTH];
   logic [31:0]         mem_npc       [DEPTH];
   logic                mem_mispred   [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;

   logic accept;
   logic store_mispred;
   logic q_valid;
   logic enq;
   logic deq;

   assign exe_ready     = (count != CW'(DEPTH));
   assign q_valid       = (count != '0);
   assign accept        = exe_valid & exe_ready;
   assign store_mispred = exe_npc_mispred & exe_npc_wb_valid;
   assign deq           = q_valid & wb_ready & ~flush;

`ifdef INTEGER_WB_BYPASS_EN
   logic bypass;
   assign bypass = ~q_valid & ~flush;
   // A bypassed result the ROB takes immediately never occupies a slot.
   assign enq    = accept & ~flush & ~(bypass & wb_ready);
`else
   assign enq    = accept & ~flush;
`endif

   always_comb begin
      wb_valid     = q_valid;
      wb_rob_id    = mem_rob_id[head];
      wb_dst_valid = mem_dst_valid[head];
      wb_dst       = mem_dst[head];
      wb_npc_valid = mem_npc_valid[head];
      wb_npc       = mem_npc[head];
      wb_mispred   = mem_mispred[head];
`ifdef INTEGER_WB_BYPASS_EN
      if (bypass) begin
         wb_valid     = exe_valid;
         wb_rob_id    = exe_rob_id;
         wb_dst_valid = exe_dst_valid;
         wb_dst       = exe_dst;
         wb_npc_valid = exe_npc_wb_valid;
         wb_npc       = exe_npc;
         wb_mispred   = store_mispred;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_rob_id[i]    <= '0;
            mem_dst_valid[i] <= 1'b0;
            mem_dst[i]       <= '0;
            mem_npc_valid[i] <= 1'b0;
            mem_npc[i]       <= '0;
            mem_mispred[i]   <= 1'b0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            mem_rob_id[tail]    <= exe_rob_id;
            mem_dst_valid[tail] <= exe_dst_valid;
            mem_dst[tail]       <= exe_dst;
            mem_npc_valid[tail] <= exe_npc_wb_valid;
            mem_npc[tail]       <= exe_npc;
            mem_mispred[tail]   <= store_mispred;
            tail                <= tail + AW'(1);
         end
         if (deq) begin
            head <= head + AW'(1);
         end
         count <= count + CW'(enq) - CW'(deq);
      end
   end

   // Statistic survives flush and counts any accepted mispredict, bypassed or not.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         mispred_cnt <= '0;
      end else if (accept && store_mispred && !(&mispred_cnt)) begin
         mispred_cnt <= mispred_cnt + MISPRED_CNT_W'(1);
      end
   end

endmodule

// File: doc/integer_wb_buffer.md
Name: integer_wb_buffer

Overview:
- Receiving end of the integer execute result interface.
- Captures the combinational outputs of the integer execute stage into a small FIFO: ROB id, destination value and valid, npc, npc write-back valid, mispredict flag.
- Presents entries to the ROB integer write-back port with a valid/ready handshake.
- Back-pressures issue through exe_ready; supports pipeline flush; keeps a saturating mispredict statistic.

Parameters:
- DEPTH, 4, number of buffered results (power of two, >=2).
- MISPRED_CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  input  1  clock
- rst_aL  input  1  asynchronous active-low reset
- exe_valid  input  1  execute result valid this cycle
- exe_ready  output  1  buffer can accept a result; issue stalls when low
- exe_rob_id  input  rob_id_t  instr_rob_id_out from execute
- exe_dst_valid  input  1  result writes a register
- exe_dst  input  reg_data_t (32)  result value
- exe_npc_wb_valid  input  1  branch or jalr; npc must be written to ROB
- exe_npc_mispred  input  1  direction/target mispredict flag
- exe_npc  input  addr_t (32)  next pc
- flush  input  1  synchronous pipeline flush
- wb_valid  output  1  head entry valid toward ROB
- wb_ready  input  1  ROB accepts head this cycle
- wb_rob_id  output  rob_id_t  head ROB id
- wb_dst_valid  output  1  head register-write valid
- wb_dst  output  32  head result value
- wb_npc_valid  output  1  head npc write valid
- wb_npc  output  32  head npc
- wb_mispred  output  1  head mispredict (already masked)
- mispred_cnt  output  MISPRED_CNT_W  saturating count of accepted mispredicting entries

Behaviour:
- Clock and reset: single clock clk; reset rst_aL asynchronous, active-low.
- Reset state: pointers=0, count=0, mispred_cnt=0; wb_valid=0, exe_ready=1. All wb_* data outputs read 0 (storage cleared on reset).
- Enqueue: exe_valid & exe_ready at posedge writes the tail and increments the tail pointer, wrapping at DEPTH.
- Stored fields:
  - mispred is stored as exe_npc_mispred & exe_npc_wb_valid.
  - dst_valid and npc fields are stored unmodified.
- Dequeue: wb_valid & wb_ready at posedge advances the head pointer, wrapping at DEPTH.
- Ready and valid:
  - exe_ready = (count != DEPTH). No same-cycle credit from a dequeue, so a full buffer never enqueues even while dequeuing.
  - wb_valid = (count != 0). wb_* always show the head entry, registered. No combinational path from exe_* to wb_*.
- Latency: a result accepted at edge N is visible on wb_* from cycle N+1 when the buffer was empty.
- Ordering: results leave in strict acceptance order.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: count unchanged, both pointers advance.
- wb_valid is held with stable data until wb_ready; the ROB may hold wb_ready high permanently.
- flush=1 at a posedge:
  - pointers and count go to 0; wb_valid=0 next cycle.
  - any enqueue or dequeue in that cycle is discarded.
  - mispred_cnt is NOT cleared; the counter still counts an entry accepted in the flush cycle.
- mispred_cnt increments on each enqueue with stored mispred=1. It saturates at all-ones.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- INTEGER_WB_BYPASS_EN defined:
  - When count==0 and flush==0, exe_* pass combinationally to wb_* with wb_valid=exe_valid.
  - If wb_ready is also high, the result is consumed with zero latency and not written.
  - Otherwise it is enqueued as normal.
  - exe_ready is unchanged.
- Not defined: behaviour as above, 1-cycle minimum latency.

Test Plan:
- Reset, then one result (rob_id=3, dst_valid=1, dst=0x0000_002A, npc_wb_valid=0, mispred=1) with wb_ready=1 -> next cycle wb_valid=1, wb_rob_id=3, wb_dst=0x2A, wb_mispred=0; mispred_cnt stays 0; following cycle wb_valid=0.
- wb_ready=0, push 4 results rob_id 1..4 -> exe_ready=0 after the 4th. A 5th push is ignored. Raise wb_ready -> wb_rob_id 1,2,3,4 on consecutive cycles, then wb_valid=0.
- Full buffer, exe_valid=1 and wb_ready=1 in the same cycle -> rob_id 1 drains, new entry not accepted, count=3, exe_ready=1 next cycle.
- Branch result npc_wb_valid=1, mispred=1, npc=0x0000_1000, dst_valid=0 -> wb_npc_valid=1, wb_npc=0x1000, wb_mispred=1, wb_dst_valid=0; mispred_cnt=1.
- 3 entries buffered, flush=1 with exe_valid=1 -> next cycle wb_valid=0, exe_ready=1; the next push appears alone at head.
- Force mispred_cnt to all-ones, then push one more mispredict -> mispred_cnt stays 0xFFFF. Assert rst_aL=0 between clock edges -> all outputs reset immediately.
